// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, held at zero while clr is high.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);
  // One cycle ahead of tick, so the owner can register a last-cycle strobe.
  assign pre_tick = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as an 8N1 UART frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empt,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   tx_q, tx_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   baud_clr, baud_tick, baud_pre;

  assign baud_clr = !(state_q inside {START, DATA, STOP});

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .tick    (baud_tick),
    .pre_tick(baud_pre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fifo_empt is only looked at in IDLE; an active frame always runs to STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_en && !fifo_empt) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (baud_tick) state_d = DATA;
      DATA:    if (baud_tick && (bit_idx_q == LAST_BIT)) state_d = STOP;
      STOP:    if (baud_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (state_q == LOAD) begin
      shift_d = fifo_data;
    end else if ((state_q == DATA) && baud_tick) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    rd_en_d   = (state_d == FETCH);
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_q == STOP) && baud_pre;
    case (state_d)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= STOP_LVL;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model on the read port, UART line decoder as reference.
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int SW_C [3] = '{2, 3, 7};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empt;
  logic [7:0] fifo_data;
  logic       fifo_rd_en, tx, busy, tx_done;

  logic       sw_en = 1'b0;
  logic       sw_empt = 1'b1;
  logic [7:0] sw_data [3];
  logic       sw_rd [3];
  logic       sw_tx [3];
  logic       sw_busy [3];
  logic       sw_done [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empt(fifo_empt), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) u_sw2 (
    .clk(clk), .rst(rst), .tx_en(sw_en), .fifo_empt(sw_empt), .fifo_data(sw_data[0]),
    .fifo_rd_en(sw_rd[0]), .tx(sw_tx[0]), .busy(sw_busy[0]), .tx_done(sw_done[0])
  );
  fifo_uart_tx #(.CLKS_PER_BIT(3)) u_sw3 (
    .clk(clk), .rst(rst), .tx_en(sw_en), .fifo_empt(sw_empt), .fifo_data(sw_data[1]),
    .fifo_rd_en(sw_rd[1]), .tx(sw_tx[1]), .busy(sw_busy[1]), .tx_done(sw_done[1])
  );
  fifo_uart_tx #(.CLKS_PER_BIT(7)) u_sw7 (
    .clk(clk), .rst(rst), .tx_en(sw_en), .fifo_empt(sw_empt), .fifo_data(sw_data[2]),
    .fifo_rd_en(sw_rd[2]), .tx(sw_tx[2]), .busy(sw_busy[2]), .tx_done(sw_done[2])
  );

  // FIFO read-port model: data and empty flag registered on the pop edge.
  logic [7:0] fq [$];
  int pops;
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) pops <= pops + 1;
    if (fifo_rd_en === 1'b1 && fq.size() != 0) begin
      fifo_data <= fq[0];
      fifo_empt <= (fq.size() == 1);
      void'(fq.pop_front());
    end else begin
      fifo_empt <= (fq.size() == 0);
    end
  end

  logic rec = 1'b0;
  logic rec_sw = 1'b0;
  logic tx_log [$];
  logic done_log [$];
  logic rd_log [$];
  logic busy_log [$];
  logic sw_tx_log [3][$];
  logic sw_done_log [3][$];
  logic sw_rd_log [3][$];
  logic sw_busy_log [3][$];
  int   sw_cnt_log [3][$];

  always @(posedge clk) begin
    #1;
    if (rec) begin
      tx_log.push_back(tx);
      done_log.push_back(tx_done);
      rd_log.push_back(fifo_rd_en);
      busy_log.push_back(busy);
    end
    if (rec_sw) begin
      for (int g = 0; g < 3; g++) begin
        sw_tx_log[g].push_back(sw_tx[g]);
        sw_done_log[g].push_back(sw_done[g]);
        sw_rd_log[g].push_back(sw_rd[g]);
        sw_busy_log[g].push_back(sw_busy[g]);
      end
      sw_cnt_log[0].push_back(int'(u_sw2.u_baud.cnt_q));
      sw_cnt_log[1].push_back(int'(u_sw3.u_baud.cnt_q));
      sw_cnt_log[2].push_back(int'(u_sw7.u_baud.cnt_q));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // UART receiver: finds each start edge, samples every bit mid-period.
  task automatic decode(input logic q [$], input int c, output int st [$], output int by [$],
                        output int nbad);
    int i;
    st.delete();
    by.delete();
    nbad = 0;
    i = 0;
    while (i + 10 * c <= q.size()) begin
      if (q[i] === 1'b0 && (i == 0 || q[i-1] === 1'b1)) begin
        int b;
        b = 0;
        for (int k = 0; k < 8; k++) if (q[i + (k + 1) * c + c / 2] === 1'b1) b = b | (1 << k);
        if (q[i + c / 2] !== 1'b0) nbad++;
        if (q[i + 9 * c + c / 2] !== 1'b1) nbad++;
        st.push_back(i);
        by.push_back(b);
        i = i + 10 * c;
      end else begin
        i++;
      end
    end
  endtask

  task automatic ones(input logic q [$], output int idx [$]);
    idx.delete();
    for (int i = 0; i < q.size(); i++) if (q[i] === 1'b1) idx.push_back(i);
  endtask

  task automatic start_rec();
    tx_log.delete();
    done_log.delete();
    rd_log.delete();
    busy_log.delete();
    rec = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle cycle %0d: tx=%b rd_en=%b busy=%b, required 1/0/0", i, tx, fifo_rd_en, busy);
      end
    end
  endtask

  task automatic test_single();
    int st [$], by [$], dn [$], rd [$];
    int nbad, p0, s;
    logic [9:0] exp_seq;
    exp_seq = 10'b1101001010;
    tx_en = 1'b1;
    p0 = pops;
    start_rec();
    fq.push_back(8'hA5);
    repeat (60) @(negedge clk);
    rec = 1'b0;
    decode(tx_log, C, st, by, nbad);
    ones(done_log, dn);
    ones(rd_log, rd);
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", pops - p0); end
    checks++; if (rd.size() != 1) begin errors++; $display("FAIL single_rd_pulses: got %0d expected 1", rd.size()); end
    checks++;
    if (st.size() != 1) begin
      errors++; $display("FAIL single_frames: got %0d expected 1", st.size());
    end else begin
      s = st[0];
      checks++; if (by[0] != 8'hA5) begin errors++; $display("FAIL single_byte: got %02h expected a5", by[0]); end
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (tx_log[s + k * C + C / 2] !== exp_seq[k]) begin
          errors++; $display("FAIL single_bit%0d: got %b expected %b", k, tx_log[s + k * C + C / 2], exp_seq[k]);
        end
      end
      checks++;
      if (rd.size() != 1 || s - rd[0] != 2) begin
        errors++; $display("FAIL single_latency: start at %0d, pop at %0d, required gap 2", s, (rd.size() > 0) ? rd[0] : -1);
      end
      checks++;
      if (dn.size() != 1 || dn[0] - s != 10 * C - 1) begin
        errors++; $display("FAIL single_tx_done: pulses %0d first at %0d, required 1 at %0d", dn.size(), (dn.size() > 0) ? dn[0] : -1, s + 10 * C - 1);
      end
      checks++;
      if (busy_log[s] !== 1'b1 || busy_log[s + 10 * C] !== 1'b0) begin
        errors++; $display("FAIL single_busy: in-frame %b after %b, required 1 and 0", busy_log[s], busy_log[s + 10 * C]);
      end
    end
  endtask

  task automatic run_bytes(input string name, input int vals [$]);
    int st [$], by [$], dn [$], rd [$];
    int nbad, p0, n;
    n = vals.size();
    tx_en = 1'b1;
    p0 = pops;
    start_rec();
    foreach (vals[i]) fq.push_back(8'(vals[i]));
    repeat (n * (10 * C + 3) + 20) @(negedge clk);
    rec = 1'b0;
    decode(tx_log, C, st, by, nbad);
    ones(done_log, dn);
    ones(rd_log, rd);
    checks++; if (pops - p0 != n) begin errors++; $display("FAIL %s_pops: got %0d expected %0d", name, pops - p0, n); end
    checks++; if (rd.size() != n) begin errors++; $display("FAIL %s_rd_pulses: got %0d expected %0d", name, rd.size(), n); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL %s_framing: got %0d bad start/stop bits expected 0", name, nbad); end
    checks++;
    if (st.size() != n || dn.size() != n) begin
      errors++; $display("FAIL %s_frames: got %0d frames %0d done pulses expected %0d", name, st.size(), dn.size(), n);
    end else begin
      for (int j = 0; j < n; j++) begin
        checks++;
        if (by[j] != vals[j]) begin errors++; $display("FAIL %s_byte%0d: got %02h expected %02h", name, j, by[j], vals[j]); end
        checks++;
        if (dn[j] - st[j] != 10 * C - 1) begin errors++; $display("FAIL %s_done%0d: got offset %0d expected %0d", name, j, dn[j] - st[j], 10 * C - 1); end
        if (j > 0) begin
          checks++;
          if (st[j] - st[j-1] != 10 * C + 3) begin
            errors++; $display("FAIL %s_gap%0d: got spacing %0d expected %0d", name, j, st[j] - st[j-1], 10 * C + 3);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vals [$];
    vals = '{8'h00, 8'hFF, 8'h3C};
    run_bytes("b2b", vals);
  endtask

  task automatic test_random();
    int vals [$];
    int n;
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) vals.push_back($urandom_range(0, 255));
    run_bytes("rand", vals);
  endtask

  task automatic test_tx_en();
    int st [$], by [$], dn [$], rd [$];
    int nbad, p0, a, bad;
    tx_en = 1'b0;
    a = $urandom_range(0, 255);
    fq.push_back(8'(a));
    fq.push_back(8'($urandom_range(0, 255)));
    p0 = pops;
    start_rec();
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || pops != p0) begin errors++; $display("FAIL txen_off: got %0d active cycles %0d pops expected 0 and 0", bad, pops - p0); end
    tx_en = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL txen_pop_next: got rd_en %b expected 1", fifo_rd_en); end
    repeat (15) @(negedge clk);
    tx_en = 1'b0;
    repeat (70) @(negedge clk);
    rec = 1'b0;
    decode(tx_log, C, st, by, nbad);
    ones(done_log, dn);
    ones(rd_log, rd);
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL txen_pops: got %0d expected 1", pops - p0); end
    checks++;
    if (st.size() != 1 || by[0] != a || nbad != 0) begin
      errors++; $display("FAIL txen_frame: got %0d frames first %02h expected 1 frame of %02h", st.size(), (by.size() > 0) ? by[0] : -1, a);
    end
    checks++; if (dn.size() != 1) begin errors++; $display("FAIL txen_done: got %0d pulses expected 1", dn.size()); end
    fq.delete();
  endtask

  task automatic test_reset_mid();
    int st [$], by [$], dn [$];
    int nbad, p0, b, dn_cnt;
    bit found;
    tx_en = 1'b0;
    fq.delete();
    repeat (3) @(negedge clk);
    b = $urandom_range(0, 255);
    p0 = pops;
    fq.push_back(8'h55);
    fq.push_back(8'(b));
    tx_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_fetch: got no pop within 20 cycles expected one"); end
    dn_cnt = 0;
    repeat (2 + 4 * C + 1) begin
      @(negedge clk);
      if (tx_done === 1'b1) dn_cnt++;
    end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got tx %b expected 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++;
    if (tx_done !== 1'b0 || dn_cnt != 0) begin
      errors++; $display("FAIL rstmid_no_done: got tx_done %b and %0d earlier pulses expected 0", tx_done, dn_cnt);
    end
    rst = 1'b0;
    start_rec();
    repeat (60) @(negedge clk);
    rec = 1'b0;
    decode(tx_log, C, st, by, nbad);
    ones(done_log, dn);
    checks++;
    if (st.size() != 1 || by[0] != b || nbad != 0) begin
      errors++; $display("FAIL rstmid_next_frame: got %0d frames first %02h expected 1 frame of %02h", st.size(), (by.size() > 0) ? by[0] : -1, b);
    end
    checks++;
    if (st.size() != 1 || dn.size() != 1 || dn[0] - st[0] != 10 * C - 1) begin
      errors++; $display("FAIL rstmid_next_done: got %0d pulses expected 1 at frame end", dn.size());
    end
    checks++; if (pops - p0 != 2) begin errors++; $display("FAIL rstmid_pops: got %0d expected 2", pops - p0); end
  endtask

  task automatic test_sweep();
    int st [$], by [$], dn [$], rd [$];
    int nbad, c, mx, last;
    int exp_b [3];
    for (int g = 0; g < 3; g++) begin
      exp_b[g] = $urandom_range(0, 255);
      sw_data[g] = 8'(exp_b[g]);
      sw_tx_log[g].delete();
      sw_done_log[g].delete();
      sw_rd_log[g].delete();
      sw_busy_log[g].delete();
      sw_cnt_log[g].delete();
    end
    @(negedge clk);
    rec_sw = 1'b1;
    sw_empt = 1'b0;
    sw_en = 1'b1;
    @(negedge clk);
    sw_en = 1'b0;
    repeat (2) @(negedge clk);
    sw_empt = 1'b1;
    repeat (10 * 7 + 20) @(negedge clk);
    rec_sw = 1'b0;
    for (int g = 0; g < 3; g++) begin
      c = SW_C[g];
      decode(sw_tx_log[g], c, st, by, nbad);
      ones(sw_done_log[g], dn);
      ones(sw_rd_log[g], rd);
      mx = 0;
      for (int i = 0; i < sw_cnt_log[g].size(); i++) if (sw_cnt_log[g][i] > mx) mx = sw_cnt_log[g][i];
      checks++;
      if (st.size() != 1 || by[0] != exp_b[g] || nbad != 0) begin
        errors++; $display("FAIL sweep%0d_frame: got %0d frames first %02h expected 1 frame of %02h", c, st.size(), (by.size() > 0) ? by[0] : -1, exp_b[g]);
      end
      checks++;
      if (st.size() != 1 || dn.size() != 1 || dn[0] - st[0] + 1 != 10 * c) begin
        errors++; $display("FAIL sweep%0d_length: got %0d pulses length %0d expected 1 pulse length %0d", c, dn.size(),
                           (st.size() > 0 && dn.size() > 0) ? dn[0] - st[0] + 1 : -1, 10 * c);
      end
      checks++; if (rd.size() != 1) begin errors++; $display("FAIL sweep%0d_pops: got %0d expected 1", c, rd.size()); end
      checks++; if (mx != c - 1) begin errors++; $display("FAIL sweep%0d_baud_max: got %0d expected %0d", c, mx, c - 1); end
      last = sw_busy_log[g].size() - 1;
      checks++; if (sw_busy_log[g][last] !== 1'b0) begin errors++; $display("FAIL sweep%0d_idle_busy: got %b expected 0", c, sw_busy_log[g][last]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_tx_en();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
